sram_arbiter: RTL and testbench

Two-port round-robin arbiter and timing sequencer for the board's asynchronous 512K×16 SRAM. Requesters (e.g. a pixel/pattern engine and a host bridge) issue single-word read/write transactions. The block serialises them onto the SRAM strobes (ADR, DAT, RAMCS/RAMOE/RAMWE/RAMLB/RAMUB) with fixed, parameterised access timing. It sits between user logic and the top-level pin assignments. DAT tristating is done in the top level from the `sram_dq_*` signals.

---
 rtl/sram_arbiter.sv | 215 +++++++++++++++++++++
 tb/tb_sram_arbiter.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_arbiter.sv
// sram_arbiter: two-port round-robin arbiter and timing sequencer for an
// asynchronous 512Kx16 SRAM. Each granted transaction runs
// IDLE -> SETUP -> ACCESS (WAIT_CYCLES) -> DONE -> IDLE.
// Every SRAM-facing output, ack, rdata and busy comes straight from a flop.
module sram_arbiter #(
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic        req1,
  input  logic        we0,
  input  logic        we1,
  input  logic [18:0] addr0,
  input  logic [18:0] addr1,
  input  logic [15:0] wdata0,
  input  logic [15:0] wdata1,
  input  logic [1:0]  be0,
  input  logic [1:0]  be1,
  output logic        ack0,
  output logic        ack1,
  output logic [15:0] rdata,
  output logic        busy,
  output logic [18:0] sram_addr,
  output logic [15:0] sram_dq_o,
  input  logic [15:0] sram_dq_i,
  output logic        sram_dq_oe,
  output logic        sram_cs_n,
  output logic        sram_oe_n,
  output logic        sram_we_n,
  output logic        sram_lb_n,
  output logic        sram_ub_n
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  // Counter reload value: the ACCESS state lasts CNT_LOAD+1 cycles.
  localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

  state_t      state_q;
  logic        last_q;      // port granted most recently
  logic        port_q;      // port owning the current transaction
  logic        we_q;        // latched direction of the current transaction
  logic [3:0]  cnt_q;
  logic        ack0_q;
  logic        ack1_q;
  logic [15:0] rdata_q;
  logic        busy_q;
  logic [18:0] addr_q;
  logic [15:0] dq_o_q;
  logic        dq_oe_q;
  logic        cs_n_q;
  logic        oe_n_q;
  logic        we_n_q;
  logic        lb_n_q;
  logic        ub_n_q;

  logic        gnt_valid_s;
  logic        gnt_port_s;
  logic        win_we_s;
  logic [18:0] win_addr_s;
  logic [15:0] win_wdata_s;
  logic [1:0]  win_be_s;

  // Round-robin grant decision: on contention the port not granted last wins.
  always_comb begin
    gnt_valid_s = 1'b0;
    gnt_port_s  = 1'b0;
    if (req0 && req1) begin
      gnt_valid_s = 1'b1;
      gnt_port_s  = ~last_q;
    end else if (req0) begin
      gnt_valid_s = 1'b1;
      gnt_port_s  = 1'b0;
    end else if (req1) begin
      gnt_valid_s = 1'b1;
      gnt_port_s  = 1'b1;
    end else begin
      gnt_valid_s = 1'b0;
      gnt_port_s  = 1'b0;
    end
  end

  // Select the winning port's transaction fields for latching at grant.
  always_comb begin
    win_we_s    = we0;
    win_addr_s  = addr0;
    win_wdata_s = wdata0;
    win_be_s    = be0;
    if (gnt_port_s) begin
      win_we_s    = we1;
      win_addr_s  = addr1;
      win_wdata_s = wdata1;
      win_be_s    = be1;
    end else begin
      win_we_s    = we0;
      win_addr_s  = addr0;
      win_wdata_s = wdata0;
      win_be_s    = be0;
    end
  end

  // Sequencer FSM; each strobe is set on the edge entering the state it belongs to.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      last_q  <= 1'b1;
      port_q  <= 1'b0;
      we_q    <= 1'b0;
      cnt_q   <= 4'd0;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      rdata_q <= 16'h0000;
      busy_q  <= 1'b0;
      addr_q  <= 19'd0;
      dq_o_q  <= 16'h0000;
      dq_oe_q <= 1'b0;
      cs_n_q  <= 1'b1;
      oe_n_q  <= 1'b1;
      we_n_q  <= 1'b1;
      lb_n_q  <= 1'b1;
      ub_n_q  <= 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (gnt_valid_s) begin
            state_q <= ST_SETUP;
            last_q  <= gnt_port_s;
            port_q  <= gnt_port_s;
            we_q    <= win_we_s;
            busy_q  <= 1'b1;
            addr_q  <= win_addr_s;
            cs_n_q  <= 1'b0;
            lb_n_q  <= ~win_be_s[0];
            ub_n_q  <= ~win_be_s[1];
            we_n_q  <= 1'b1;
            oe_n_q  <= win_we_s;
            dq_oe_q <= win_we_s;
            if (win_we_s) begin
              dq_o_q <= win_wdata_s;
            end else begin
              dq_o_q <= dq_o_q;
            end
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_SETUP: begin
          cnt_q   <= CNT_LOAD;
          we_n_q  <= ~we_q;
          state_q <= ST_ACCESS;
        end
        ST_ACCESS: begin
          if (cnt_q == 4'd0) begin
            state_q <= ST_DONE;
            we_n_q  <= 1'b1;
            ack0_q  <= ~port_q;
            ack1_q  <= port_q;
            if (!we_q) begin
              rdata_q <= sram_dq_i;
            end else begin
              rdata_q <= rdata_q;
            end
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        ST_DONE: begin
          // Turnaround: release the bus for one full IDLE cycle.
          state_q <= ST_IDLE;
          ack0_q  <= 1'b0;
          ack1_q  <= 1'b0;
          busy_q  <= 1'b0;
          cs_n_q  <= 1'b1;
          oe_n_q  <= 1'b1;
          we_n_q  <= 1'b1;
          lb_n_q  <= 1'b1;
          ub_n_q  <= 1'b1;
          dq_oe_q <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          ack0_q  <= 1'b0;
          ack1_q  <= 1'b0;
          busy_q  <= 1'b0;
          cs_n_q  <= 1'b1;
          oe_n_q  <= 1'b1;
          we_n_q  <= 1'b1;
          lb_n_q  <= 1'b1;
          ub_n_q  <= 1'b1;
          dq_oe_q <= 1'b0;
        end
      endcase
    end
  end

  assign ack0       = ack0_q;
  assign ack1       = ack1_q;
  assign rdata      = rdata_q;
  assign busy       = busy_q;
  assign sram_addr  = addr_q;
  assign sram_dq_o  = dq_o_q;
  assign sram_dq_oe = dq_oe_q;
  assign sram_cs_n  = cs_n_q;
  assign sram_oe_n  = oe_n_q;
  assign sram_we_n  = we_n_q;
  assign sram_lb_n  = lb_n_q;
  assign sram_ub_n  = ub_n_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter: a W=2 instance with a behavioural SRAM,
// plus W=1 and W=15 instances for write-pulse width and ack latency.
module tb_sram_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0, req1, we0, we1;
  logic [18:0] addr0, addr1;
  logic [15:0] wdata0, wdata1;
  logic [1:0]  be0, be1;
  logic        ack0, ack1, busy;
  logic [15:0] rdata;
  logic [18:0] sram_addr;
  logic [15:0] sram_dq_o, sram_dq_i;
  logic        sram_dq_oe, sram_cs_n, sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n;

  // Parameter-sweep instances (only port 0 used)
  logic        r1_req, r15_req;
  logic        a1_ack0, a1_ack1, a1_busy, a1_oe, a1_cs, a1_oen, a1_wen, a1_lb, a1_ub;
  logic [15:0] a1_rdata, a1_dq;
  logic [18:0] a1_addr;
  logic        a15_ack0, a15_ack1, a15_busy, a15_oe, a15_cs, a15_oen, a15_wen, a15_lb, a15_ub;
  logic [15:0] a15_rdata, a15_dq;
  logic [18:0] a15_addr;

  logic [15:0] mem [0:524287];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sram_arbiter #(.WAIT_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .be0(be0), .be1(be1), .ack0(ack0), .ack1(ack1), .rdata(rdata), .busy(busy),
    .sram_addr(sram_addr), .sram_dq_o(sram_dq_o), .sram_dq_i(sram_dq_i),
    .sram_dq_oe(sram_dq_oe), .sram_cs_n(sram_cs_n), .sram_oe_n(sram_oe_n),
    .sram_we_n(sram_we_n), .sram_lb_n(sram_lb_n), .sram_ub_n(sram_ub_n)
  );

  sram_arbiter #(.WAIT_CYCLES(1)) dut_w1 (
    .clk(clk), .rst(rst), .req0(r1_req), .req1(1'b0), .we0(1'b1), .we1(1'b0),
    .addr0(19'h00abc), .addr1(19'd0), .wdata0(16'h5a5a), .wdata1(16'h0000),
    .be0(2'b11), .be1(2'b00), .ack0(a1_ack0), .ack1(a1_ack1), .rdata(a1_rdata),
    .busy(a1_busy), .sram_addr(a1_addr), .sram_dq_o(a1_dq), .sram_dq_i(16'h0000),
    .sram_dq_oe(a1_oe), .sram_cs_n(a1_cs), .sram_oe_n(a1_oen), .sram_we_n(a1_wen),
    .sram_lb_n(a1_lb), .sram_ub_n(a1_ub)
  );

  sram_arbiter #(.WAIT_CYCLES(15)) dut_w15 (
    .clk(clk), .rst(rst), .req0(r15_req), .req1(1'b0), .we0(1'b1), .we1(1'b0),
    .addr0(19'h00abc), .addr1(19'd0), .wdata0(16'h5a5a), .wdata1(16'h0000),
    .be0(2'b11), .be1(2'b00), .ack0(a15_ack0), .ack1(a15_ack1), .rdata(a15_rdata),
    .busy(a15_busy), .sram_addr(a15_addr), .sram_dq_o(a15_dq), .sram_dq_i(16'h0000),
    .sram_dq_oe(a15_oe), .sram_cs_n(a15_cs), .sram_oe_n(a15_oen), .sram_we_n(a15_wen),
    .sram_lb_n(a15_lb), .sram_ub_n(a15_ub)
  );

  // Behavioural asynchronous SRAM: byte-lane writes while cs_n and we_n are low.
  assign sram_dq_i = mem[sram_addr];

  always @(posedge clk) begin
    if (!sram_cs_n && !sram_we_n) begin
      if (!sram_lb_n) mem[sram_addr][7:0]  <= sram_dq_o[7:0];
      if (!sram_ub_n) mem[sram_addr][15:8] <= sram_dq_o[15:8];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Issue one transaction on the W=2 instance and wait (bounded) for its ack.
  task automatic run_txn(input bit port, input logic we, input logic [18:0] a,
                         input logic [15:0] d, input logic [1:0] be,
                         output int lat, output int wel, output int oel,
                         output logic [15:0] rd, output bit other_ack);
    if (port) begin
      req1 = 1'b1; we1 = we; addr1 = a; wdata1 = d; be1 = be;
    end else begin
      req0 = 1'b1; we0 = we; addr0 = a; wdata0 = d; be0 = be;
    end
    lat = 0; wel = 0; oel = 0; rd = 16'h0000; other_ack = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (!sram_we_n) wel++;
      if (!sram_oe_n) oel++;
      if (port ? ack0 : ack1) other_ack = 1'b1;
      if (port ? ack1 : ack0) begin
        lat = n;
        rd  = rdata;
        break;
      end
    end
    req0 = 1'b0;
    req1 = 1'b0;
    @(negedge clk);
  endtask

  int          lat, wel, oel;
  logic [15:0] rd;
  bit          oth;
  bit          ack_seen, both_ack;
  int          nacks, cyc;
  bit          ord [6];
  int          tk [6];
  logic [15:0] rdv [6];
  int          lat1, lat15, wel1, wel15;

  initial begin
    for (int i = 0; i < 524288; i++) mem[i] = 16'h0000;
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
    addr0 = 19'd0; addr1 = 19'd0; wdata0 = 16'h0000; wdata1 = 16'h0000;
    be0 = 2'b00; be1 = 2'b00; r1_req = 1'b0; r15_req = 1'b0;
    repeat (3) @(negedge clk);

    // Reset values
    check("rst_cs_n", 32'(sram_cs_n), 32'd1);
    check("rst_oe_n", 32'(sram_oe_n), 32'd1);
    check("rst_we_n", 32'(sram_we_n), 32'd1);
    check("rst_lb_ub", 32'({sram_lb_n, sram_ub_n}), 32'd3);
    check("rst_dq_oe", 32'(sram_dq_oe), 32'd0);
    check("rst_addr", 32'(sram_addr), 32'd0);
    check("rst_dq_o", 32'(sram_dq_o), 32'd0);
    check("rst_rdata", 32'(rdata), 32'd0);
    check("rst_acks", 32'({ack0, ack1}), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_busy", 32'(busy), 32'd0);

    // Single write, cycle by cycle: request sampled in T0
    req0 = 1'b1; we0 = 1'b1; addr0 = 19'h12345; wdata0 = 16'hBEEF; be0 = 2'b11;
    @(negedge clk); // T1 SETUP
    check("setup_cs_n", 32'(sram_cs_n), 32'd0);
    check("setup_dq_oe", 32'(sram_dq_oe), 32'd1);
    check("setup_we_n", 32'(sram_we_n), 32'd1);
    check("setup_oe_n", 32'(sram_oe_n), 32'd1);
    check("setup_addr", 32'(sram_addr), 32'h12345);
    check("setup_dq_o", 32'(sram_dq_o), 32'hBEEF);
    check("setup_lb_ub", 32'({sram_lb_n, sram_ub_n}), 32'd0);
    check("setup_busy", 32'(busy), 32'd1);
    @(negedge clk); // T2
    check("acc1_we_n", 32'(sram_we_n), 32'd0);
    check("acc1_ack0", 32'(ack0), 32'd0);
    @(negedge clk); // T3
    check("acc2_we_n", 32'(sram_we_n), 32'd0);
    check("acc2_ack0", 32'(ack0), 32'd0);
    @(negedge clk); // T4 DONE
    check("done_we_n", 32'(sram_we_n), 32'd1);
    check("done_ack0", 32'(ack0), 32'd1);
    check("done_ack1", 32'(ack1), 32'd0);
    check("done_cs_held", 32'(sram_cs_n), 32'd0);
    check("done_dq_oe_held", 32'(sram_dq_oe), 32'd1);
    req0 = 1'b0;
    @(negedge clk); // T5 IDLE turnaround
    check("ta_strobes", 32'({sram_cs_n, sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n}), 32'h1f);
    check("ta_dq_oe", 32'(sram_dq_oe), 32'd0);
    check("ta_busy", 32'(busy), 32'd0);
    check("ta_ack0", 32'(ack0), 32'd0);
    check("mem_write", 32'(mem[19'h12345]), 32'hBEEF);

    // Read-back on port 1
    run_txn(1'b1, 1'b0, 19'h12345, 16'h0000, 2'b11, lat, wel, oel, rd, oth);
    check("rd_latency", 32'(lat), 32'd4);
    check("rd_data", 32'(rd), 32'hBEEF);
    check("rd_oe_low", 32'(oel), 32'd4);
    check("rd_we_low", 32'(wel), 32'd0);
    check("rd_ack0_quiet", 32'(oth), 32'd0);

    // Byte lanes: low byte only
    run_txn(1'b0, 1'b1, 19'h12345, 16'h00AA, 2'b01, lat, wel, oel, rd, oth);
    check("be01_latency", 32'(lat), 32'd4);
    check("be01_we_low", 32'(wel), 32'd2);
    check("be01_mem", 32'(mem[19'h12345]), 32'hBEAA);
    run_txn(1'b0, 1'b0, 19'h12345, 16'h0000, 2'b11, lat, wel, oel, rd, oth);
    check("be01_rd_low", 32'(rd[7:0]), 32'hAA);
    // be=00 write is a no-op but still acked
    run_txn(1'b0, 1'b1, 19'h12345, 16'h5555, 2'b00, lat, wel, oel, rd, oth);
    check("be00_latency", 32'(lat), 32'd4);
    check("be00_mem", 32'(mem[19'h12345]), 32'hBEAA);

    // Reset in the middle of a write (ACCESS state)
    req0 = 1'b1; we0 = 1'b1; addr0 = 19'h00777; wdata0 = 16'h1234; be0 = 2'b11;
    @(negedge clk); // SETUP
    @(negedge clk); // ACCESS
    check("mid_in_access", 32'(sram_we_n), 32'd0);
    rst = 1'b1;
    req0 = 1'b0;
    ack_seen = 1'b0;
    @(negedge clk);
    check("mid_rst_strobes", 32'({sram_cs_n, sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n}), 32'h1f);
    check("mid_rst_dq_oe", 32'(sram_dq_oe), 32'd0);
    if (ack0 || ack1) ack_seen = 1'b1;
    repeat (2) begin
      @(negedge clk);
      if (ack0 || ack1) ack_seen = 1'b1;
    end
    rst = 1'b0;
    @(negedge clk);
    if (ack0 || ack1) ack_seen = 1'b1;
    check("mid_rst_no_ack", 32'(ack_seen), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);

    // Contention: both ports held continuously; port 0 wins first after reset
    req0 = 1'b1; we0 = 1'b1; addr0 = 19'h00100; wdata0 = 16'h1111; be0 = 2'b11;
    req1 = 1'b1; we1 = 1'b0; addr1 = 19'h12345; be1 = 2'b11;
    nacks = 0; cyc = 0; both_ack = 1'b0;
    for (int n = 0; n < 6; n++) begin
      ord[n] = 1'b0; tk[n] = 0; rdv[n] = 16'h0000;
    end
    while (nacks < 6 && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (ack0 && ack1) both_ack = 1'b1;
      if (ack0 || ack1) begin
        ord[nacks] = ack1;
        tk[nacks]  = cyc;
        rdv[nacks] = rdata;
        nacks++;
      end
    end
    req0 = 1'b0;
    req1 = 1'b0;
    @(negedge clk);
    check("cont_count", 32'(nacks), 32'd6);
    check("cont_both_ack", 32'(both_ack), 32'd0);
    check("cont_first_lat", 32'(tk[0]), 32'd4);
    for (int n = 0; n < 6; n++) begin
      check($sformatf("cont_order%0d", n), 32'(ord[n]), 32'(n % 2));
    end
    for (int n = 1; n < 6; n++) begin
      check($sformatf("cont_spacing%0d", n), 32'(tk[n] - tk[n-1]), 32'd5);
    end
    check("cont_rd1", 32'(rdv[1]), 32'hBEAA);
    check("cont_mem0", 32'(mem[19'h00100]), 32'h1111);

    // Parameter sweep: W=1 and W=15 write pulse width and ack latency
    r1_req = 1'b1; r15_req = 1'b1;
    lat1 = 0; lat15 = 0; wel1 = 0; wel15 = 0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (!a1_wen) wel1++;
      if (!a15_wen) wel15++;
      if (a1_ack0 && lat1 == 0) begin
        lat1 = n; r1_req = 1'b0;
      end
      if (a15_ack0 && lat15 == 0) begin
        lat15 = n; r15_req = 1'b0;
      end
      if (lat1 != 0 && lat15 != 0) break;
    end
    r1_req = 1'b0; r15_req = 1'b0;
    check("w1_latency", 32'(lat1), 32'd3);
    check("w1_we_low", 32'(wel1), 32'd1);
    check("w15_latency", 32'(lat15), 32'd17);
    check("w15_we_low", 32'(wel15), 32'd15);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
